// File: rtl/load_store_unit_if.sv
// Memory-side request/grant/rvalid bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if #(parameter int DATA_WIDTH = 32);
  logic                    mem_req;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic [3:0]              mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 byte/half/word load-store sequencer; store done 2 cycles, load 3, fault 1 after accept (minimum).
// Holds mem_req until mem_gnt and waits for mem_rvalid indefinitely; busy stalls the pipeline meanwhile.
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  done,
  output logic                  busy,
  output logic                  fault,
  load_store_unit_if.master     mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        bad;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;

  // Decode of the incoming request: byte enables, replicated store data, fault.
  always_comb begin
    bad      = 1'b0;
    be_in    = 4'b0000;
    wdata_in = WriteData;
    case (funct3)
      3'b000, 3'b100: begin
        be_in    = 4'b0001 << ALUResult[1:0];
        wdata_in = {4{WriteData[7:0]}};
        bad      = MemWrite & funct3[2];
      end
      3'b001, 3'b101: begin
        be_in    = ALUResult[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{WriteData[15:0]}};
        bad      = ALUResult[0] | (MemWrite & funct3[2]);
      end
      3'b010: begin
        be_in = 4'b1111;
        bad   = |ALUResult[1:0];
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    lane_byte = mem.mem_rdata[7:0];
    case (off_q)
      2'd1:    lane_byte = mem.mem_rdata[15:8];
      2'd2:    lane_byte = mem.mem_rdata[23:16];
      2'd3:    lane_byte = mem.mem_rdata[31:24];
      default: lane_byte = mem.mem_rdata[7:0];
    endcase
    lane_half = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_val = {24'h0, lane_byte};
      3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_val = {16'h0, lane_half};
      default: load_val = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    mem.mem_req = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = bad ? DONE : REQ;
      end
      REQ: begin
        mem.mem_req = 1'b1;
        if (mem.mem_gnt) state_nxt = mem.mem_we ? DONE : WAIT;
      end
      WAIT: if (mem.mem_rvalid) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ReadData      <= '0;
      fault         <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= 4'b0000;
      mem.mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        f3_q          <= funct3;
        off_q         <= ALUResult[1:0];
        fault         <= bad;
        mem.mem_we    <= MemWrite;
        mem.mem_addr  <= {ALUResult[31:2], 2'b00};
        mem.mem_be    <= be_in;
        mem.mem_wdata <= wdata_in;
      end
      if (state == WAIT && mem.mem_rvalid) ReadData <= load_val;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector table, reset/back-to-back sequences and randomized accesses against a behavioural model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst, start, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        done, busy, fault;

  load_store_unit_if mem ();

  load_store_unit dut (
    .clk(clk), .rst(rst), .start(start), .MemWrite(MemWrite), .funct3(funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
    .done(done), .busy(busy), .fault(fault), .mem(mem.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd;

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd_exp;
    bit          flt;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && f3[2]) return 1'b1;
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int s;
    s = size_of(f3);
    return 4'(((1 << s) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (size_of(f3))
      1:       return (wd % 256) * 32'h0101_0101;
      2:       return (wd % 65536) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int     s;
    longint range, v;
    s = size_of(f3);
    if (s == 4) return rdata;
    range = longint'(1) << (8 * s);
    v = (longint'(rdata) >> (8 * (a % 4))) % range;
    if (!f3[2] && v >= range / 2) v = v - range;
    return 32'(v);
  endfunction

  // Issues one access from IDLE and plays the memory, checking the bus and the completion.
  task automatic do_access(input string tag, input bit we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                           input int gd, input int rd, input logic [3:0] ebe,
                           input logic [31:0] ewd, input logic [31:0] erd, input bit efault);
    int exp_cyc, reqs, waits;
    bit granted, seen_done;
    exp_cyc = efault ? 1 : (we ? 2 + gd : 3 + gd + rd);
    reqs = 0; waits = 0; granted = 1'b0; seen_done = 1'b0;
    @(negedge clk);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    start = 1'b1; MemWrite = we; funct3 = f3; ALUResult = a; WriteData = wd;
    for (int k = 1; k <= 40 && !seen_done; k++) begin
      @(negedge clk);
      start = 1'b0;
      MemWrite = 1'($urandom); funct3 = 3'($urandom); ALUResult = $urandom; WriteData = $urandom;
      mem.mem_gnt = 1'b0;
      mem.mem_rvalid = 1'($urandom);
      mem.mem_rdata = $urandom;
      if (done) begin
        seen_done = 1'b1;
        check({tag, " done cycle"}, 32'(k), 32'(exp_cyc));
        check({tag, " fault"}, 32'(fault), 32'(efault));
        check({tag, " ReadData"}, ReadData, erd);
        check({tag, " req cycles"}, 32'(reqs), efault ? 32'd0 : 32'(gd + 1));
      end else if (mem.mem_req) begin
        if (efault || granted) check({tag, " unexpected mem_req"}, 32'd1, 32'd0);
        check({tag, " mem_addr"}, mem.mem_addr, a & ~32'd3);
        check({tag, " mem_be"}, 32'(mem.mem_be), 32'(ebe));
        check({tag, " mem_we"}, 32'(mem.mem_we), 32'(we));
        if (we) check({tag, " mem_wdata"}, mem.mem_wdata, ewd);
        if (reqs == gd) begin
          mem.mem_gnt = 1'b1;
          granted = 1'b1;
        end
        reqs++;
      end else if (granted && !we) begin
        check({tag, " wait busy"}, 32'(busy), 32'd1);
        mem.mem_rvalid = (waits == rd);
        if (waits == rd) mem.mem_rdata = rdat;
        waits++;
      end else if (!efault && !granted) begin
        check({tag, " missing mem_req"}, 32'(mem.mem_req), 32'd1);
      end
    end
    if (!seen_done) check({tag, " done timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h100; WriteData = 0;
    mem.mem_gnt = 1'b1; mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hFFFF_FFFF;
    exp_rd = 32'h0;

    tbl[0]  = '{0, 3'b010, 32'h100, 32'h0,         32'hDEADBEEF, 0, 0, 4'hF, 32'h0,         32'hDEADBEEF, 0};
    tbl[1]  = '{0, 3'b000, 32'h103, 32'h0,         32'h80FF0000, 0, 0, 4'h8, 32'h0,         32'hFFFFFF80, 0};
    tbl[2]  = '{0, 3'b100, 32'h103, 32'h0,         32'h80FF0000, 1, 1, 4'h8, 32'h0,         32'h00000080, 0};
    tbl[3]  = '{1, 3'b001, 32'h202, 32'h1234ABCD,  32'h0,        3, 0, 4'hC, 32'hABCDABCD,  32'h00000080, 0};
    tbl[4]  = '{0, 3'b010, 32'h101, 32'h0,         32'h11111111, 0, 0, 4'h0, 32'h0,         32'h00000080, 1};
    tbl[5]  = '{1, 3'b000, 32'h001, 32'h00000055,  32'h0,        0, 0, 4'h2, 32'h55555555,  32'h00000080, 0};
    tbl[6]  = '{0, 3'b101, 32'h002, 32'h0,         32'hBEEF1234, 0, 2, 4'hC, 32'h0,         32'h0000BEEF, 0};
    tbl[7]  = '{0, 3'b001, 32'h002, 32'h0,         32'hBEEF1234, 1, 0, 4'hC, 32'h0,         32'hFFFFBEEF, 0};
    tbl[8]  = '{1, 3'b010, 32'h004, 32'hCAFEF00D,  32'h0,        0, 0, 4'hF, 32'hCAFEF00D,  32'hFFFFBEEF, 0};
    tbl[9]  = '{0, 3'b011, 32'h008, 32'h0,         32'h0,        0, 0, 4'h0, 32'h0,         32'hFFFFBEEF, 1};
    tbl[10] = '{1, 3'b100, 32'h008, 32'h0,         32'h0,        0, 0, 4'h0, 32'h0,         32'hFFFFBEEF, 1};
    tbl[11] = '{1, 3'b010, 32'h006, 32'h0,         32'h0,        0, 0, 4'h0, 32'h0,         32'hFFFFBEEF, 1};
    tbl[12] = '{0, 3'b001, 32'h001, 32'h0,         32'h0,        0, 0, 4'h0, 32'h0,         32'hFFFFBEEF, 1};
    tbl[13] = '{0, 3'b010, 32'h300, 32'h0,         32'h01234567, 2, 3, 4'hF, 32'h0,         32'h01234567, 0};

    // Reset holds everything at zero even with start and memory inputs active.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst fault", 32'(fault), 32'd0);
    check("rst ReadData", ReadData, 32'd0);
    check("rst mem_req", 32'(mem.mem_req), 32'd0);
    check("rst mem_we", 32'(mem.mem_we), 32'd0);
    check("rst mem_be", 32'(mem.mem_be), 32'd0);
    check("rst mem_addr", mem.mem_addr, 32'd0);
    check("rst mem_wdata", mem.mem_wdata, 32'd0);
    rst = 1'b0; start = 1'b0; mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_access($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                tbl[i].rdata, tbl[i].gd, tbl[i].rd, tbl[i].be, tbl[i].wdata,
                tbl[i].rd_exp, tbl[i].flt);
    end

    // Reset during WAIT, then a late rvalid.
    @(negedge clk);
    start = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h10;
    @(negedge clk);
    start = 1'b0;
    check("abortw req", 32'(mem.mem_req), 32'd1);
    mem.mem_gnt = 1'b1;
    @(negedge clk);
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h12345678;
    check("abortw busy", 32'(busy), 32'd0);
    check("abortw ReadData", ReadData, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem.mem_rvalid = 1'b0;
      check("abortw done", 32'(done), 32'd0);
      check("abortw ReadData late", ReadData, 32'd0);
      check("abortw busy late", 32'(busy), 32'd0);
    end

    // Reset during REQ with a grant present.
    start = 1'b1; MemWrite = 1'b0; funct3 = 3'b000; ALUResult = 32'h21;
    @(negedge clk);
    start = 1'b0; mem.mem_gnt = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem.mem_gnt = 1'b0;
    check("abortr req", 32'(mem.mem_req), 32'd0);
    check("abortr busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("abortr done", 32'(done), 32'd0);
    exp_rd = 32'h0;

    // Back-to-back LHU 0x2 then SW 0x4 with start held high.
    start = 1'b1; MemWrite = 1'b0; funct3 = 3'b101; ALUResult = 32'h2; WriteData = 32'h0;
    @(negedge clk);
    MemWrite = 1'b1; funct3 = 3'b010; ALUResult = 32'h4; WriteData = 32'h600DF00D;
    check("b2b lhu req", 32'(mem.mem_req), 32'd1);
    check("b2b lhu addr", mem.mem_addr, 32'h0);
    check("b2b lhu be", 32'(mem.mem_be), 32'hC);
    check("b2b lhu we", 32'(mem.mem_we), 32'd0);
    mem.mem_gnt = 1'b1;
    @(negedge clk);
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hA5A51111;
    @(negedge clk);
    mem.mem_rvalid = 1'b0;
    check("b2b lhu done", 32'(done), 32'd1);
    check("b2b lhu ReadData", ReadData, 32'h0000A5A5);
    @(negedge clk);
    check("b2b idle gap", 32'(busy), 32'd0);
    @(negedge clk);
    check("b2b sw req", 32'(mem.mem_req), 32'd1);
    check("b2b sw addr", mem.mem_addr, 32'h4);
    check("b2b sw we", 32'(mem.mem_we), 32'd1);
    check("b2b sw wdata", mem.mem_wdata, 32'h600DF00D);
    mem.mem_gnt = 1'b1;
    @(negedge clk);
    start = 1'b0; mem.mem_gnt = 1'b0;
    check("b2b sw done", 32'(done), 32'd1);
    check("b2b sw ReadData", ReadData, 32'h0000A5A5);
    exp_rd = 32'h0000A5A5;

    for (int i = 0; i < 200; i++) begin
      bit          we, flt;
      logic [2:0]  f3;
      logic [31:0] a, wd, rdat, erd;
      we = 1'($urandom);
      f3 = 3'($urandom);
      if ($urandom_range(3) != 0) begin
        case ($urandom_range(4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      a = $urandom;
      if ($urandom_range(1) != 0) a = a & ~32'(size_of(f3) - 1);
      wd = $urandom;
      rdat = $urandom;
      flt = model_fault(we, f3, a);
      erd = (flt || we) ? exp_rd : model_load(f3, a, rdat);
      do_access($sformatf("rnd%0d", i), we, f3, a, wd, rdat, $urandom_range(3),
                $urandom_range(3), model_be(f3, a), model_wdata(f3, wd), erd, flt);
      exp_rd = erd;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 DATA_WIDTH, 32, data and address width in bits; only 32 is supported.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request a memory access; sampled only in IDLE.
REQ-005 MemWrite  in  1  1 = store, 0 = load; captured at acceptance.
REQ-006 funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
REQ-007 ALUResult  in  32  byte address produced by the ALU; captured at acceptance.
REQ-008 WriteData  in  32  store data (rs2); captured at acceptance.
REQ-009 ReadData  out  32  extended load result; registered.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 busy  out  1  state != IDLE; pipeline stall request.
REQ-012 fault  out  1  misaligned or illegal access; valid only while done=1.
REQ-013 mem_req  out  1  memory request, held until granted.
REQ-014 mem_we  out  1  memory write strobe qualifier.
REQ-015 mem_addr  out  32  word address: captured address with bits [1:0] forced to 00.
REQ-016 mem_be  out  4  byte enables.
REQ-017 mem_wdata  out  32  lane-replicated store data.
REQ-018 mem_gnt  in  1  memory accepted the request this cycle.
REQ-019 mem_rvalid  in  1  mem_rdata is valid this cycle.
REQ-020 mem_rdata  in  32  read word.

Function
REQ-021 The FSM has four states: IDLE, REQ, WAIT, DONE.
REQ-022 IDLE with start=1: capture all inputs. If the access is legal and aligned, go to REQ. Otherwise go to DONE with fault latched to 1.
REQ-023 Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=00. Illegal means funct3 in {011,110,111}, or a store with funct3 100/101.
REQ-024 REQ: mem_req=1 with mem_addr, mem_we, mem_be and mem_wdata stable. On mem_gnt=1, a store goes to DONE and a load goes to WAIT. Without a grant the FSM stays in REQ indefinitely.
REQ-025 WAIT: on mem_rvalid=1, ReadData is loaded with the extracted value and the FSM goes to DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
REQ-027 mem_req is 0 in all states except REQ. No memory request is ever issued for a fault.
REQ-028 mem_rvalid is ignored outside WAIT.
REQ-029 Byte enables: B uses be=0001<<addr[1:0]; H uses 0011 when addr[1]=0, else 1100; W uses 1111. Loads drive the same be values.
REQ-030 Store data: B replicates WriteData[7:0] into all four lanes; H replicates WriteData[15:0] into both halves; W passes WriteData unchanged.
REQ-031 Load extract: the byte is selected by addr[1:0] and the half by addr[1]. B and H sign-extend; BU and HU zero-extend; W passes through.
REQ-032 ReadData changes only on load completion and holds its value otherwise, including across stores and faults.
REQ-033 fault clears to 0 on the next acceptance of a legal access.
REQ-034 Minimum latency, counted from the start-accept edge:
- store: done at cycle 2 with same-cycle grant;
- load: done at cycle 3 with grant at cycle 1 and rvalid at cycle 2;
- fault: done at cycle 1.
REQ-035 busy=1 in REQ, WAIT and DONE; busy=0 in IDLE.

Reset
REQ-036 rst=1 forces IDLE. The outputs reset as follows:
- ReadData=0, done=0, fault=0, busy=0;
- mem_req=0, mem_we=0, mem_be=0000;
- mem_addr=0, mem_wdata=0.
REQ-037 Reset asserted in REQ or WAIT aborts the access. No done is produced, and an rvalid arriving after reset is ignored.
REQ-038 rst has priority over start and over all memory inputs.

Verification
REQ-039 LW at addr 0x100: start, gnt at cycle 1, rvalid at cycle 2 with mem_rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, done at cycle 3, ReadData=0xDEADBEEF.
REQ-040 LB at addr 0x103 with mem_rdata=0x80FF_0000 -> be=1000, ReadData=0xFFFFFF80. The same access as LBU -> ReadData=0x00000080.
REQ-041 SH at addr 0x202 with WriteData=0x1234ABCD, gnt held low for 3 cycles -> mem_req held 3 cycles plus the grant cycle, mem_addr=0x200, be=1100, mem_wdata=0xABCDABCD, done one cycle after gnt.
REQ-042 LW at addr 0x101 -> done and fault=1 at cycle 1, mem_req never asserted, ReadData unchanged. A following legal SB clears fault.
REQ-043 rst pulsed during WAIT, then a late rvalid -> FSM in IDLE, no done, ReadData=0.
REQ-044 Back-to-back LHU at 0x2 and SW at 0x4 with start held high -> the second access is accepted only in IDLE after DONE. The LHU returns the upper half of mem_rdata zero-extended.
